// File: rtl/mp_addsub.sv
//-----------------------------------------------------------------------------
// mp_addsub
//
// Multi-precision unsigned adder/subtractor. One operation is accepted at a
// time and evaluated serially, one LIMB-bit limb per clock, least significant
// limb first, with a registered carry between limbs:
//
//     {carry_out, p_out} = a + b' + carry_in      (WIDTH+1 bits)
//     b' = b (sub=0)  or  ~b (sub=1)
//
// With sub=1 and carry_in=1 this is a - b mod 2^WIDTH, and carry_out=1
// means "no borrow" (a >= b).
//
// Parameters
//   WIDTH  operand/result width in bits (2..4096)
//   LIMB   bits processed per cycle (1..48); NLIMB = ceil(WIDTH/LIMB)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   operands and mode presented
//   in_ready   out  block can accept an operation (IDLE only)
//   a_in       in   first operand, unsigned
//   b_in       in   second operand, unsigned
//   sub        in   0 = add, 1 = subtract
//   carry_in   in   carry into limb 0
//   out_valid  out  result available (DONE only)
//   out_ready  in   consumer accepts result
//   p_out      out  result
//   carry_out  out  carry out of bit WIDTH-1
//   zero       out  p_out == 0
//
// Latency: out_valid rises exactly NLIMB clocks after the accept edge.
//-----------------------------------------------------------------------------
module mp_addsub #(
    parameter int WIDTH = 1024,
    parameter int LIMB  = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sub,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] p_out,
    output logic             carry_out,
    output logic             zero
);

    // Number of limbs and the padded working width.
    localparam int NLIMB = (WIDTH + LIMB - 1) / LIMB;
    localparam int PW    = NLIMB * LIMB;
    // Number of real result bits held in the top limb (1..LIMB). The carry
    // out of bit WIDTH-1 appears at this bit position of the top limb sum.
    localparam int TOPB  = WIDTH - (NLIMB - 1) * LIMB;
    localparam int CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam logic [CW-1:0] LAST_LIMB = CW'(NLIMB - 1);

    // Mask selecting the bits of the top limb that belong to p_out; padding
    // bits above them carry the final carry and must not affect 'zero'.
    function automatic logic [LIMB-1:0] top_limb_mask();
        logic [LIMB-1:0] m;
        m = {LIMB{1'b0}};
        for (int i = 0; i < LIMB; i++) begin
            m[i] = (i < TOPB) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

    localparam logic [LIMB-1:0] TOP_MASK = top_limb_mask();

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [PW-1:0]   r_a;          // remaining limbs of a, shifted down
    logic [PW-1:0]   r_b;          // remaining limbs of b', shifted down
    logic [PW-1:0]   r_p;          // result, limbs shifted in from the top
    logic            r_carry;      // inter-limb carry
    logic [CW-1:0]   r_cnt;        // limb counter
    logic            r_zacc;       // running "all limbs so far are zero"
    logic            r_carry_out;
    logic            r_zero;

    logic [WIDTH-1:0] w_b_sel;
    logic [PW-1:0]    w_a_ext;
    logic [PW-1:0]    w_b_ext;
    logic [LIMB:0]    w_sum;
    logic             w_last;
    logic             w_limb_zero;
    logic [PW-1:0]    w_p_next;

    // Operand b after optional inversion, then both operands zero-extended
    // to the padded width (inversion first, so padding stays zero).
    always_comb begin
        w_b_sel = b_in;
        w_a_ext = {PW{1'b0}};
        w_b_ext = {PW{1'b0}};
        if (sub) begin
            w_b_sel = ~b_in;
        end else begin
            w_b_sel = b_in;
        end
        w_a_ext[WIDTH-1:0] = a_in;
        w_b_ext[WIDTH-1:0] = w_b_sel;
    end

    // Limb adder: plain LIMB+1 bit add of the current low limbs and carry.
    always_comb begin
        w_sum = {1'b0, r_a[LIMB-1:0]} + {1'b0, r_b[LIMB-1:0]}
              + {{LIMB{1'b0}}, r_carry};
    end

    // Per-limb zero detect; the top limb ignores its padding bits.
    always_comb begin
        w_last      = (r_cnt == LAST_LIMB);
        w_limb_zero = 1'b0;
        if (w_last) begin
            w_limb_zero = ((w_sum[LIMB-1:0] & TOP_MASK) == {LIMB{1'b0}});
        end else begin
            w_limb_zero = (w_sum[LIMB-1:0] == {LIMB{1'b0}});
        end
    end

    // New limb enters at the top of the result register; after NLIMB
    // shifts limb 0 has reached the bottom and every limb is in place.
    always_comb begin
        w_p_next = PW'({w_sum[LIMB-1:0], r_p} >> LIMB);
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_a         <= {PW{1'b0}};
            r_b         <= {PW{1'b0}};
            r_p         <= {PW{1'b0}};
            r_carry     <= 1'b0;
            r_cnt       <= {CW{1'b0}};
            r_zacc      <= 1'b0;
            r_carry_out <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // in_ready is registered: it comes up one clock after
                    // reset release and stays up until an accept.
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_a        <= w_a_ext;
                        r_b        <= w_b_ext;
                        r_carry    <= carry_in;
                        r_cnt      <= {CW{1'b0}};
                        r_zacc     <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end else begin
                        r_state    <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_p     <= w_p_next;
                    r_a     <= r_a >> LIMB;
                    r_b     <= r_b >> LIMB;
                    r_carry <= w_sum[LIMB];
                    r_zacc  <= r_zacc & w_limb_zero;
                    if (w_last) begin
                        // Final carry comes from bit WIDTH, not the limb edge.
                        r_carry_out <= w_sum[TOPB];
                        r_zero      <= r_zacc & w_limb_zero;
                        r_out_valid <= 1'b1;
                        r_cnt       <= {CW{1'b0}};
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt       <= r_cnt + CW'(1);
                        r_state     <= S_RUN;
                    end
                end
                S_DONE: begin
                    // Results hold until the consumer takes them; a new
                    // accept can only happen from IDLE on a later edge.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_state     <= S_DONE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_cnt       <= {CW{1'b0}};
                    r_carry     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign p_out     = r_p[WIDTH-1:0];
    assign carry_out = r_carry_out;
    assign zero      = r_zero;

endmodule

// File: tb/tb_mp_addsub.sv
//-----------------------------------------------------------------------------
// tb_mp_addsub
//
// Three instances share clk/rst:
//   0: WIDTH=1024 LIMB=48 (NLIMB=22)
//   1: WIDTH=100  LIMB=48 (NLIMB=3, partial top limb)
//   2: WIDTH=40   LIMB=48 (NLIMB=1)
// Expected results come from plain wide arithmetic in model(); a negedge
// process compares every output cycle against the pending expectation.
//-----------------------------------------------------------------------------
module tb_mp_addsub;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid_i  [3];
    logic          sub_i       [3];
    logic          cin_i       [3];
    logic          out_ready_i [3];
    logic [1023:0] a_i         [3];
    logic [1023:0] b_i         [3];

    logic          in_ready_w  [3];
    logic          out_valid_w [3];
    logic          carry_w     [3];
    logic          zero_w      [3];
    logic [1023:0] p_w         [3];
    logic [1023:0] p0;
    logic [99:0]   p1;
    logic [39:0]   p2;

    assign p_w[0] = p0;
    assign p_w[1] = {924'd0, p1};
    assign p_w[2] = {984'd0, p2};

    mp_addsub #(.WIDTH(1024), .LIMB(48)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_i[0]), .in_ready(in_ready_w[0]),
        .a_in(a_i[0]), .b_in(b_i[0]), .sub(sub_i[0]), .carry_in(cin_i[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready_i[0]),
        .p_out(p0), .carry_out(carry_w[0]), .zero(zero_w[0])
    );

    mp_addsub #(.WIDTH(100), .LIMB(48)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_i[1]), .in_ready(in_ready_w[1]),
        .a_in(a_i[1][99:0]), .b_in(b_i[1][99:0]), .sub(sub_i[1]), .carry_in(cin_i[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready_i[1]),
        .p_out(p1), .carry_out(carry_w[1]), .zero(zero_w[1])
    );

    mp_addsub #(.WIDTH(40), .LIMB(48)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_i[2]), .in_ready(in_ready_w[2]),
        .a_in(a_i[2][39:0]), .b_in(b_i[2][39:0]), .sub(sub_i[2]), .carry_in(cin_i[2]),
        .out_valid(out_valid_w[2]), .out_ready(out_ready_i[2]),
        .p_out(p2), .carry_out(carry_w[2]), .zero(zero_w[2])
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: one operation in flight per instance.
    logic          pending [3];
    logic [1023:0] exp_p   [3];
    logic          exp_c   [3];
    logic          exp_z   [3];
    int            acc_cyc [3];

    function automatic int wd(input int k);
        case (k)
            0: return 1024;
            1: return 100;
            default: return 40;
        endcase
    endfunction

    function automatic int nl(input int k);
        case (k)
            0: return 22;
            1: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic logic [1024:0] wmask(input int w);
        return (1025'd1 << w) - 1025'd1;
    endfunction

    // Reference: {carry, p} = a + b' + cin over w bits, b' = ~b for subtract.
    function automatic logic [1024:0] model(input logic [1023:0] a, input logic [1023:0] b,
                                            input logic s, input logic ci, input int w);
        logic [1024:0] m;
        logic [1024:0] aa;
        logic [1024:0] bb;
        m  = wmask(w);
        aa = {1'b0, a} & m;
        bb = s ? (~{1'b0, b} & m) : ({1'b0, b} & m);
        return aa + bb + {1024'd0, ci};
    endfunction

    function automatic logic [1023:0] rand1024();
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [1024:0] act, input logic [1024:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Compare process: every negedge, every instance.
    logic ov_prev [3];
    logic hs_prev [3];
    initial begin
        for (int k = 0; k < 3; k++) begin
            ov_prev[k] = 1'b0;
            hs_prev[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (rst) begin
                    ov_prev[k] = 1'b0;
                    hs_prev[k] = 1'b0;
                end else begin
                    if (hs_prev[k]) begin
                        chk($sformatf("in_ready_after_hs[%0d]", k), in_ready_w[k], 1);
                        chk($sformatf("out_valid_after_hs[%0d]", k), out_valid_w[k], 0);
                    end
                    chk($sformatf("ready_valid_excl[%0d]", k), in_ready_w[k] & out_valid_w[k], 0);
                    hs_prev[k] = 1'b0;
                    if (out_valid_w[k]) begin
                        if (!pending[k]) begin
                            chk($sformatf("unexpected_out_valid[%0d]", k), out_valid_w[k], 0);
                        end else begin
                            if (!ov_prev[k])
                                chk($sformatf("latency[%0d]", k), cyc - acc_cyc[k], nl(k));
                            chk($sformatf("p_out[%0d]", k), {1'b0, p_w[k]}, {1'b0, exp_p[k]});
                            chk($sformatf("carry_out[%0d]", k), carry_w[k], exp_c[k]);
                            chk($sformatf("zero[%0d]", k), zero_w[k], exp_z[k]);
                            if (out_ready_i[k]) begin
                                hs_prev[k] = 1'b1;
                                pending[k] = 1'b0;
                            end
                        end
                    end
                    ov_prev[k] = out_valid_w[k];
                end
            end
        end
    end

    task automatic post_expect(input int k, input logic [1023:0] a, input logic [1023:0] b,
                               input logic s, input logic ci);
        logic [1024:0] r;
        logic [1024:0] m;
        int w;
        w  = wd(k);
        m  = wmask(w);
        r  = model(a, b, s, ci, w);
        exp_p[k]   = r[1023:0] & m[1023:0];
        exp_c[k]   = r[w];
        exp_z[k]   = ((r & m) == 1025'd0);
        acc_cyc[k] = cyc + 1;
        pending[k] = 1'b1;
    endtask

    // One complete operation; hold = cycles out_ready stays low in DONE.
    task automatic do_op(input int k, input logic [1023:0] a, input logic [1023:0] b,
                         input logic s, input logic ci, input int hold);
        int t;
        t = 0;
        while (!in_ready_w[k] && t < 100) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready_w[k]) begin
            chk($sformatf("timeout_in_ready[%0d]", k), in_ready_w[k], 1);
            return;
        end
        a_i[k] = a; b_i[k] = b; sub_i[k] = s; cin_i[k] = ci;
        in_valid_i[k] = 1'b1;
        post_expect(k, a, b, s, ci);
        @(posedge clk); #1;
        // Inputs after accept must not matter.
        in_valid_i[k] = 1'b0;
        a_i[k] = rand1024(); b_i[k] = rand1024();
        sub_i[k] = 1'($urandom); cin_i[k] = 1'($urandom);
        t = 0;
        while (!out_valid_w[k] && t < 200) begin
            out_ready_i[k] = 1'($urandom);
            in_valid_i[k]  = 1'($urandom);
            @(posedge clk); #1; t++;
        end
        if (!out_valid_w[k]) begin
            chk($sformatf("timeout_out_valid[%0d]", k), out_valid_w[k], 1);
            pending[k] = 1'b0;
            in_valid_i[k] = 1'b0;
            return;
        end
        out_ready_i[k] = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid_i[k] = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("hold_in_ready[%0d]", k), in_ready_w[k], 0);
        end
        in_valid_i[k]  = 1'b0;
        out_ready_i[k] = 1'b1;
        @(posedge clk); #1;
        out_ready_i[k] = 1'b0;
    endtask

    task automatic rand_op(input int k, input int hold);
        logic [1023:0] a;
        logic [1023:0] b;
        int mode;
        a = rand1024(); b = rand1024();
        mode = $urandom_range(0, 5);
        case (mode)
            1: a = ~1024'd0;
            2: b = a;
            3: begin a = 1024'd0; b = 1024'd0; end
            4: b = ~1024'd0;
            default: ;
        endcase
        do_op(k, a, b, 1'($urandom), 1'($urandom), hold);
    endtask

    initial begin
        logic [1023:0] x;
        for (int k = 0; k < 3; k++) begin
            in_valid_i[k] = 1'b0; sub_i[k] = 1'b0; cin_i[k] = 1'b0;
            out_ready_i[k] = 1'b0; a_i[k] = 1024'd0; b_i[k] = 1024'd0;
            pending[k] = 1'b0;
        end

        // Pin the model with hand-computed results.
        chk("pin_model_036", model((1024'd1 << 100) - 1024'd1, 1024'd1, 1'b0, 1'b0, 100), 1025'd1 << 100);
        chk("pin_model_037", model(1024'd5, 1024'd7, 1'b1, 1'b1, 100), (1025'd1 << 100) - 1025'd2);
        chk("pin_model_038", model(1024'h0123456789ABCDEF0123, 1024'h0123456789ABCDEF0123, 1'b1, 1'b1, 100),
            1025'd1 << 100);
        chk("pin_model_040", model(1024'd3, 1024'd4, 1'b0, 1'b1, 100), 1025'd8);

        // Reset state.
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_in_ready[%0d]", k), in_ready_w[k], 0);
            chk($sformatf("rst_out_valid[%0d]", k), out_valid_w[k], 0);
            chk($sformatf("rst_p_out[%0d]", k), {1'b0, p_w[k]}, 1025'd0);
            chk($sformatf("rst_carry[%0d]", k), carry_w[k], 0);
            chk($sformatf("rst_zero[%0d]", k), zero_w[k], 0);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("in_ready_still_low_after_release", in_ready_w[0], 0);
        @(posedge clk); #1;
        chk("in_ready_first_cycle_after_release", in_ready_w[0], 1);

        // Directed vectors, WIDTH=100.
        do_op(1, (1024'd1 << 100) - 1024'd1, 1024'd1, 1'b0, 1'b0, 0);
        chk("d036_p", {1'b0, p_w[1]}, 1025'd0);
        chk("d036_c", carry_w[1], 1);
        chk("d036_z", zero_w[1], 1);
        do_op(1, 1024'd5, 1024'd7, 1'b1, 1'b1, 2);
        chk("d037_p", {1'b0, p_w[1]}, (1025'd1 << 100) - 1025'd2);
        chk("d037_c", carry_w[1], 0);
        chk("d037_z", zero_w[1], 0);
        do_op(1, 1024'h0123456789ABCDEF0123, 1024'h0123456789ABCDEF0123, 1'b1, 1'b1, 0);
        chk("d038_p", {1'b0, p_w[1]}, 1025'd0);
        chk("d038_c", carry_w[1], 1);
        chk("d038_z", zero_w[1], 1);

        // Directed vectors, WIDTH=40 (single limb) and WIDTH=1024.
        do_op(2, (1024'd1 << 40) - 1024'd1, 1024'd0, 1'b0, 1'b1, 0);
        chk("d40_p", {1'b0, p_w[2]}, 1025'd0);
        chk("d40_c", carry_w[2], 1);
        chk("d40_z", zero_w[2], 1);
        do_op(0, 1024'd0, 1024'd1, 1'b1, 1'b1, 0);
        chk("d1024_p", {1'b0, p_w[0]}, {1'b0, ~1024'd0});
        chk("d1024_c", carry_w[0], 0);
        chk("d1024_z", zero_w[0], 0);

        // Random operations.
        for (int i = 0; i < 1000; i++) rand_op(0, (i == 500) ? 10 : int'($urandom_range(0, 1)));
        for (int i = 0; i < 60; i++) rand_op(1, int'($urandom_range(0, 2)));
        for (int i = 0; i < 100; i++) rand_op(2, int'($urandom_range(0, 2)));

        // Abort in RUN limb 1 on the WIDTH=100 instance.
        while (!in_ready_w[1]) begin @(posedge clk); #1; end
        x = ~1024'd0;
        a_i[1] = x; b_i[1] = x; sub_i[1] = 1'b0; cin_i[1] = 1'b1;
        in_valid_i[1] = 1'b1;
        @(posedge clk); #1;
        in_valid_i[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        pending[1] = 1'b0;
        #1;
        chk("abort_p_out", {1'b0, p_w[1]}, 1025'd0);
        chk("abort_carry", carry_w[1], 0);
        chk("abort_zero", zero_w[1], 0);
        chk("abort_out_valid", out_valid_w[1], 0);
        chk("abort_in_ready", in_ready_w[1], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_ready_back", in_ready_w[1], 1);
        do_op(1, 1024'd3, 1024'd4, 1'b0, 1'b1, 0);
        chk("d040_p", {1'b0, p_w[1]}, 1025'd8);
        chk("d040_c", carry_w[1], 0);
        chk("d040_z", zero_w[1], 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
